// File: rtl/rr_mux_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_reg_if
// Description : Channel-side and output-side handshake bundle for rr_mux_reg.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_mux_reg_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SELW = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SELW-1:0]         out_src;
    logic                    out_valid;
    logic                    out_ready;

    // Producer/consumer side (testbench or surrounding logic)
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    // Arbitrating mux side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/rr_mux_reg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_reg
// Description : N-input round-robin arbitrating mux with registered output.
//               Define RR_MUX_FIXED_PRIO_EN for lowest-index fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic        clk,
    input  logic        rst,
    rr_mux_reg_if.slave bus
);
    localparam int SELW = $clog2(NUM_IN);

    logic [NUM_IN-1:0] w_grant;
    logic [NUM_IN-1:0] w_in_ready;
    logic [SELW-1:0]   w_sel;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_can_load;
    logic              w_xfer;

    logic [WIDTH-1:0]  r_data;
    logic [SELW-1:0]   r_src;
    logic              r_valid;

`ifdef RR_MUX_FIXED_PRIO_EN
    // Scan downward so the lowest valid index is the last one written
    always_comb begin
        w_grant = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
            end
        end
    end
`else
    logic [SELW-1:0] r_ptr;
    int              w_idx;
    logic            w_found;

    // Search starts just past the last winner and wraps around
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_IN;
            for (int i = 0; i < NUM_IN; i++) begin
                if (!w_found && (i == w_idx) && bus.in_valid[i]) begin
                    w_grant[i] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= SELW'(NUM_IN - 1);
        end else if (w_xfer) begin
            r_ptr <= w_sel;
        end
    end
`endif

    always_comb begin
        w_sel      = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant[i]) begin
                w_sel      = SELW'(i);
                w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_can_load = !r_valid || bus.out_ready;
    assign w_in_ready = (rst || !w_can_load) ? '0 : w_grant;
    assign w_xfer     = |(w_in_ready & bus.in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_src   <= w_sel;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_data;
    assign bus.out_src   = r_src;
    assign bus.out_valid = r_valid;
endmodule
`default_nettype wire
